// File: rtl/mem_arbiter.sv
// Two-port data-memory arbiter: pipeline MEM stage (port 0) vs loader/debug (port 1).
// Port 0 has priority until port 1 has been passed over MAX_WAIT times; one access in flight.
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_ld,
  input  logic              p0_st,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_done,
  output logic              stall_M,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_done,
  output logic              m_ld,
  output logic              m_st,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready
);

  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

  localparam logic [3:0] MAX_W4 = 4'(MAX_WAIT);

  state_t     state, state_nxt;
  logic [3:0] starve_cnt;
  logic       lat_st;
  logic       p0_any;
  logic       gnt0, gnt1;
  logic       busy;
  logic       fin0, fin1;

  assign p0_any  = p0_ld | p0_st;
  assign busy    = (state != IDLE);
  assign fin0    = (state == BUSY0) & m_ready;
  assign fin1    = (state == BUSY1) & m_ready;
  assign stall_M = p0_any & ~p0_done;
  assign m_ld    = busy & ~lat_st;
  assign m_st    = busy & lat_st;

  // No grant at all in a done cycle: the finishing requester still shows its
  // old request, and letting the other port slip in here would break the
  // MAX_WAIT fairness count under continuous contention.
  always_comb begin
    state_nxt = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    case (state)
      IDLE: begin
        if (!(p0_done | p1_done)) begin
          if (p0_any && (!p1_req || starve_cnt < MAX_W4)) begin
            gnt0      = 1'b1;
            state_nxt = BUSY0;
          end else if (p1_req) begin
            gnt1      = 1'b1;
            state_nxt = BUSY1;
          end
        end
      end
      BUSY0:   if (m_ready) state_nxt = IDLE;
      BUSY1:   if (m_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      lat_st     <= 1'b0;
      p0_done    <= 1'b0;
      p1_done    <= 1'b0;
      p0_rdata   <= '0;
      p1_rdata   <= '0;
      m_addr     <= '0;
      m_wdata    <= '0;
    end else begin
      state   <= state_nxt;
      p0_done <= fin0;
      p1_done <= fin1;
      if (gnt0) begin
        m_addr  <= p0_addr;
        m_wdata <= p0_wdata;
        lat_st  <= p0_st;
        if (p1_req && starve_cnt < MAX_W4) starve_cnt <= starve_cnt + 4'd1;
      end
      if (gnt1) begin
        m_addr     <= p1_addr;
        m_wdata    <= p1_wdata;
        lat_st     <= p1_we;
        starve_cnt <= '0;
      end
      if (fin0 && !lat_st) p0_rdata <= m_rdata;
      if (fin1 && !lat_st) p1_rdata <= m_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single accesses, fairness, reset abort, stall behaviour.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        p0_ld, p0_st;
  logic [31:0] p0_addr, p0_wdata, p0_rdata;
  logic        p0_done, stall_M;
  logic        p1_req, p1_we;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic        p1_done;
  logic        m_ld, m_st;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_ready;

  int checks   = 0;
  int failures = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .p0_ld(p0_ld), .p0_st(p0_st), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_rdata(p0_rdata), .p0_done(p0_done), .stall_M(stall_M),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_rdata(p1_rdata), .p1_done(p1_done),
    .m_ld(m_ld), .m_st(m_st), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int rec[$];
  int exp_seq[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

  initial begin
    rst = 1'b0;
    p0_ld = 0; p0_st = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
    m_rdata = 0; m_ready = 0;
    repeat (2) @(negedge clk);
    chk("rst_m_ld", m_ld, 0);
    chk("rst_m_st", m_st, 0);
    chk("rst_dones", {p0_done, p1_done}, 0);
    chk("rst_rdata", {p0_rdata, p1_rdata}, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0);

    // Single port-0 load, one memory wait cycle, granted in first cycle out of reset
    rst = 1'b1;
    p0_ld = 1; p0_addr = 32'h10;
    #1 chk("t1_stall_req", stall_M, 1);
    chk("t1_idle_m_ld", m_ld, 0);
    @(negedge clk);
    chk("t1_m_ld", m_ld, 1);
    chk("t1_m_addr", m_addr, 32'h10);
    chk("t1_stall_busy", stall_M, 1);
    @(negedge clk);
    chk("t1_wait_m_ld", m_ld, 1);
    chk("t1_wait_done", p0_done, 0);
    m_ready = 1; m_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("t1_done", p0_done, 1);
    chk("t1_rdata", p0_rdata, 32'hDEADBEEF);
    chk("t1_stall_done", stall_M, 0);
    chk("t1_done_m_ld", m_ld, 0);
    p0_ld = 0; m_ready = 0;
    @(negedge clk);
    chk("t1_done_once", p0_done, 0);
    chk("t1_addr_hold", m_addr, 32'h10);

    // Port-1 store, request dropped mid-access
    p1_req = 1; p1_we = 1; p1_addr = 32'h20; p1_wdata = 32'h55;
    @(negedge clk);
    chk("t2_m_st", {m_ld, m_st}, 2'b01);
    chk("t2_m_wdata", m_wdata, 32'h55);
    chk("t2_m_addr", m_addr, 32'h20);
    p1_req = 0;
    @(negedge clk);
    chk("t2_hold_m_st", m_st, 1);
    m_ready = 1; m_rdata = 32'h12345678;
    @(negedge clk);
    chk("t2_done", p1_done, 1);
    chk("t2_rdata_keep", p1_rdata, 0);
    chk("t2_idle_m_st", m_st, 0);
    @(negedge clk);
    chk("t2_done_once", p1_done, 0);

    // Spurious m_ready in IDLE (m_ready still high)
    @(negedge clk);
    chk("t3_dones", {p0_done, p1_done}, 0);
    chk("t3_cmd", {m_ld, m_st}, 0);
    m_ready = 0;

    // Simultaneous requests with starve_cnt=0
    p0_ld = 1; p0_addr = 32'h30; p1_req = 1; p1_we = 0; p1_addr = 32'h40;
    m_ready = 1; m_rdata = 32'h0000A5A5;
    @(negedge clk);
    chk("t4_first_p0", {m_ld, m_addr}, {1'b1, 32'h30});
    @(negedge clk);
    chk("t4_p0_done", p0_done, 1);
    chk("t4_no_grant_done", {m_ld, m_st}, 0);
    p0_ld = 0;
    @(negedge clk);
    chk("t4_idle_gap", {m_ld, m_st, p1_done}, 0);
    @(negedge clk);
    chk("t4_p1_grant", {m_ld, m_addr}, {1'b1, 32'h40});
    @(negedge clk);
    chk("t4_p1_done", p1_done, 1);
    chk("t4_p1_rdata", p1_rdata, 32'h0000A5A5);
    p1_req = 0; m_ready = 0;
    @(negedge clk);

    // Continuous contention: 4 port-0 grants, then 1 port-1 grant, repeating
    p0_ld = 1; p0_addr = 32'h100; p1_req = 1; p1_we = 0; p1_addr = 32'h200;
    m_ready = 1; m_rdata = 32'h1111;
    for (int c = 0; c < 100 && rec.size() < 10; c++) begin
      @(negedge clk);
      if (p0_done) rec.push_back(0);
      if (p1_done) rec.push_back(1);
    end
    p0_ld = 0; p1_req = 0; m_ready = 0;
    chk("t5_count", rec.size(), 10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("t5_seq%0d", i), (i < rec.size()) ? rec[i] : 99, exp_seq[i]);
    @(negedge clk);
    chk("t5_quiet", {m_ld, m_st}, 0);

    // Reset during BUSY0 before m_ready
    p0_ld = 1; p0_addr = 32'h50;
    @(negedge clk);
    chk("t6_busy", m_ld, 1);
    #2 rst = 1'b0;
    #1 chk("t6_async_m_ld", m_ld, 0);
    @(negedge clk);
    chk("t6_no_done", p0_done, 0);
    chk("t6_addr_clr", m_addr, 0);
    chk("t6_p1_rdata_clr", p1_rdata, 0);
    rst = 1'b1;
    #1 chk("t6_idle", m_ld, 0);
    @(negedge clk);
    chk("t6_regrant", {m_ld, m_addr}, {1'b1, 32'h50});
    m_ready = 1; m_rdata = 32'h77;
    @(negedge clk);
    chk("t6_done", p0_done, 1);
    chk("t6_rdata", p0_rdata, 32'h77);
    p0_ld = 0; m_ready = 0;
    @(negedge clk);

    // Port 0 arrives during BUSY1; ld+st together acts as a store
    p1_req = 1; p1_we = 1; p1_addr = 32'h60; p1_wdata = 32'h99;
    @(negedge clk);
    p0_ld = 1; p0_st = 1; p0_addr = 32'h70; p0_wdata = 32'hAB;
    #1 chk("t7_stall_busy1", stall_M, 1);
    chk("t7_p1_cmd", {m_st, m_addr, m_wdata}, {1'b1, 32'h60, 32'h99});
    m_ready = 1;
    @(negedge clk);
    chk("t7_p1_done", p1_done, 1);
    chk("t7_stall_held", stall_M, 1);
    p1_req = 0;
    @(negedge clk);
    chk("t7_gap", {m_ld, m_st}, 0);
    @(negedge clk);
    chk("t7_p0_store", {m_ld, m_st}, 2'b01);
    chk("t7_p0_cmd", {m_addr, m_wdata}, {32'h70, 32'hAB});
    @(negedge clk);
    chk("t7_p0_done", p0_done, 1);
    chk("t7_stall_clr", stall_M, 0);
    chk("t7_rdata_keep", p0_rdata, 32'h77);
    p0_ld = 0; p0_st = 0; m_ready = 0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
